// File: rtl/adc_sequencer.sv
// Sequencer that drives a SAR ADC through 2^avg_log2 conversions and reports sum and average.
// Optional WAIT timeout and sticky err flag are built only when ADC_SEQ_TIMEOUT_EN is defined.
module adc_sequencer #(
    parameter int TIMEOUT_CYCLES = 63,
    parameter int GAP_W          = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic             cont,
    input  logic [2:0]       avg_log2,
    input  logic [GAP_W-1:0] gap,
    output logic             adc_go,
    input  logic             adc_valid,
    input  logic             adc_sample,
    input  logic [4:0]       adc_result,
    output logic [11:0]      sum,
    output logic [4:0]       avg,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic             sampling
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GO,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [11:0]      acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
    logic [GAP_W-1:0] gapCfg_q, gapCfg_d;
    logic [2:0]       avgLog2_q, avgLog2_d;
    logic [11:0]      sum_q, sum_d;
    logic [4:0]       avg_q, avg_d;
    logic             adcGo_q;
    logic             done_q;
    logic             busy_q;
    logic             sampling_q;

    logic [11:0]      accSum;
    logic [7:0]       cntNext;
    logic [7:0]       target;
    logic             timeoutHit;

    // 128 samples of at most 31 peak at 3968, so the 12-bit accumulator cannot wrap.
    assign accSum  = acc_q + {7'd0, adc_result};
    assign cntNext = cnt_q + 8'd1;
    assign target  = 8'd1 << avgLog2_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        gapCnt_d  = gapCnt_q;
        gapCfg_d  = gapCfg_q;
        avgLog2_d = avgLog2_q;
        sum_d     = sum_q;
        avg_d     = avg_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d   = S_GO;
                        acc_d     = '0;
                        cnt_d     = '0;
                        avgLog2_d = avg_log2;
                        gapCfg_d  = gap;
                    end
                end
                S_GO: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (adc_valid) begin
                        acc_d = accSum;
                        cnt_d = cntNext;
                        if (cntNext == target) begin
                            state_d = S_DONE;
                            sum_d   = accSum;
                            avg_d   = 5'(accSum >> avgLog2_q);
                        end else begin
                            state_d  = S_GAP;
                            gapCnt_d = gapCfg_q;
                        end
                    end else if (timeoutHit) begin
                        state_d = S_DONE;
                        sum_d   = acc_q;
                        avg_d   = 5'(acc_q >> avgLog2_q);
                    end
                end
                S_GAP: begin
                    // A gap of 0 or 1 both give a single GAP cycle.
                    if (gapCnt_q <= GAP_W'(1)) begin
                        state_d  = S_GO;
                        gapCnt_d = '0;
                    end else begin
                        gapCnt_d = gapCnt_q - GAP_W'(1);
                    end
                end
                S_DONE: begin
                    if (cont) begin
                        state_d   = S_GO;
                        acc_d     = '0;
                        cnt_d     = '0;
                        avgLog2_d = avg_log2;
                        gapCfg_d  = gap;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            gapCnt_q   <= '0;
            gapCfg_q   <= '0;
            avgLog2_q  <= '0;
            sum_q      <= '0;
            avg_q      <= '0;
            adcGo_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            sampling_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            gapCnt_q   <= gapCnt_d;
            gapCfg_q   <= gapCfg_d;
            avgLog2_q  <= avgLog2_d;
            sum_q      <= sum_d;
            avg_q      <= avg_d;
            adcGo_q    <= (state_d == S_GO);
            done_q     <= (state_d == S_DONE);
            busy_q     <= (state_d != S_IDLE);
            sampling_q <= adc_sample;
        end
    end

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] tmr_q;
    logic             err_q;
    logic             startAccept;

    assign startAccept = (state_q == S_IDLE) && start && !abort;
    assign timeoutHit  = (state_q == S_WAIT) && !adc_valid &&
                         (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

    // The timer counts consecutive WAIT cycles; err stays set until the next accepted start.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_WAIT && !adc_valid && !abort) begin
                tmr_q <= tmr_q + TMR_W'(1);
            end else begin
                tmr_q <= '0;
            end
            if (startAccept) begin
                err_q <= 1'b0;
            end else if (timeoutHit && !abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign timeoutHit = 1'b0;
    assign err        = 1'b0;
`endif

    assign adc_go   = adcGo_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign sum      = sum_q;
    assign avg      = avg_q;
    assign sampling = sampling_q;

endmodule

// File: doc/adc_sequencer.md
ADC_SEQUENCER -- requirements
Module: adc_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 63: maximum CLK cycles allowed from adc_go to adc_valid.
REQ-002 The block SHALL have parameter GAP_W, default 8: width of the inter-conversion gap field.
REQ-003 The block SHALL have one clock, CLK; reset RST is asynchronous and active-high.
REQ-004 Ports SHALL be:
- CLK  in  1  clock
- RST  in  1  async active-high reset
- start  in  1  one-cycle request to begin a sequence
- abort  in  1  one-cycle request to cancel the sequence
- cont  in  1  continuous mode; re-run after each DONE
- avg_log2  in  3  samples per sequence = 2^avg_log2, i.e. 1..128
- gap  in  GAP_W  idle CLK cycles between conversions
- adc_go  out  1  conversion request to SARADC GO
- adc_valid  in  1  SARADC VALID, a one-cycle result strobe
- adc_sample  in  1  SARADC SAMPLE, status only
- adc_result  in  5  SARADC RESULT
- sum  out  12  accumulated sum of the last completed sequence
- avg  out  5  sum >> avg_log2, truncated
- done  out  1  one-cycle pulse when sum/avg update
- busy  out  1  high in any state except IDLE
- err  out  1  sticky timeout flag
- sampling  out  1  registered copy of adc_sample

Function
REQ-005 The FSM SHALL have the states IDLE, GO, WAIT, GAP and DONE.
REQ-006 IDLE->GO SHALL occur on start; on that transition the block clears the accumulator and sample count, latches avg_log2 and gap, and clears err.
REQ-007 In GO, adc_go SHALL be 1 for exactly one cycle, then the FSM moves to WAIT; adc_go SHALL be 0 in every other state.
REQ-008 In WAIT, adc_valid SHALL add adc_result zero-extended to 12 bits into the accumulator and increment the count.
- If count reaches 2^avg_log2, the FSM moves to DONE.
- Otherwise it moves to GAP with a countdown loaded from the latched gap.
REQ-009 In GAP, the countdown SHALL decrement each cycle and move to GO when it reaches 0; with gap=0, GAP lasts exactly one cycle.
REQ-010 In DONE, the block SHALL register sum=acc and avg=acc>>avg_log2, and assert done for exactly one cycle.
- If cont=1, the next state is GO, with the accumulator/count cleared and config re-latched.
- Otherwise the next state is IDLE.
REQ-011 sum and avg SHALL hold their values until the next DONE and SHALL NOT change mid-sequence.
REQ-012 start while busy=1 SHALL be ignored.
REQ-013 abort SHALL force IDLE from any state on the next edge, with adc_go=0, no done, and sum/avg unchanged; abort has priority over start and over adc_valid in the same cycle.
REQ-014 adc_valid outside WAIT SHALL be ignored.
REQ-015 The maximum sum is 31*128 = 3968; the accumulator SHALL be 12 bits and SHALL NOT wrap.
REQ-016 sampling SHALL follow adc_sample with one cycle of latency.

Reset
REQ-017 Asserting RST SHALL asynchronously force the following: state=IDLE; adc_go=0, done=0, busy=0, err=0, sampling=0; sum=0, avg=0; accumulator, count and countdown all 0.
REQ-018 Deasserting RST SHALL take effect synchronously; the first start is accepted on the first edge after release.
REQ-019 RST asserted mid-sequence SHALL discard the partial accumulation.

Configuration
REQ-020 Macro ADC_SEQ_TIMEOUT_EN SHALL control the WAIT timeout.
- When defined: a counter runs in WAIT. If TIMEOUT_CYCLES cycles elapse without adc_valid, the block sets err=1 and enters DONE with the partial sum, asserting done.
- When undefined: there is no counter, WAIT waits indefinitely, and err is tied to 0.

Verification
REQ-021 avg_log2=0, gap=0, start; adc_valid with result=21 three cycles after adc_go -> one adc_go pulse; done pulse; sum=21, avg=21; busy falls to 0.
REQ-022 avg_log2=2, gap=3; results 10, 11, 12, 13 -> four adc_go pulses, each GAP lasting 3 cycles; sum=46, avg=11.
REQ-023 avg_log2=7 with all results 31 -> sum=3968, avg=31, no overflow.
REQ-024 cont=1, avg_log2=1, results 4, 6, then 8, 8 -> done twice, avg=5 then avg=8; no IDLE cycle between sequences.
REQ-025 abort asserted in WAIT in the same cycle as adc_valid -> IDLE next cycle; no done; sum unchanged.
REQ-026 With ADC_SEQ_TIMEOUT_EN defined, no adc_valid for 63 cycles -> err=1 and done pulse; the next start clears err.
